// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst types, response codes and beat address/legality helpers
//
// Purpose: types and pure functions used by axi_burst_sram_slave for address
// sequencing and per-beat legality.
// Contents: burst_t (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR, axi_next_addr(),
// beat_legal().
// Configuration: AXI_SLV_WRAP_EN - when defined WRAP bursts with len 1/3/7/15
// are legal; when undefined every WRAP beat is illegal.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

    // Address of the beat following addr. INCR realigns to the transfer size so
    // an unaligned first beat is followed by aligned beats.
    function automatic logic [AXI_ADDR_W-1:0] axi_next_addr(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_SIZE_W-1:0] size,
        input logic [AXI_LEN_W-1:0]  len,
        input logic [1:0]            burst
    );
        logic [AXI_ADDR_W-1:0] step;
        logic [AXI_ADDR_W-1:0] mask;
        logic [AXI_ADDR_W-1:0] nxt;
        step = AXI_ADDR_W'(1) << size;
        mask = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
        if (burst == INCR) begin
            nxt = (addr & ~(step - AXI_ADDR_W'(1))) + step;
        end else if (burst == WRAP) begin
            nxt = (addr & ~mask) | ((addr + step) & mask);
        end else begin
            nxt = addr;
        end
        return nxt;
    endfunction

    // A beat is legal when its size fits the data bus, its address falls inside
    // the array window and the burst type/length combination is supported.
    // lg_bytes is log2 of the data bus width in bytes.
    function automatic logic beat_legal(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_SIZE_W-1:0] size,
        input logic [AXI_LEN_W-1:0]  len,
        input logic [1:0]            burst,
        input logic [AXI_ADDR_W-1:0] base,
        input int unsigned           depth,
        input int unsigned           lg_bytes
    );
        logic [63:0] off;
        logic [63:0] lim;
        logic        ok;
        ok  = 1'b1;
        off = 64'(addr) - 64'(base);
        lim = 64'(depth) << lg_bytes;
        if (32'(size) > lg_bytes) ok = 1'b0;
        if (addr < base)          ok = 1'b0;
        if (off >= lim)           ok = 1'b0;
        if (burst == 2'b11)       ok = 1'b0;
        if (burst == WRAP) begin
`ifdef AXI_SLV_WRAP_EN
            if (!(len == AXI_LEN_W'(1) || len == AXI_LEN_W'(3) ||
                  len == AXI_LEN_W'(7) || len == AXI_LEN_W'(15)))
                ok = 1'b0;
`else
            ok = 1'b0;
`endif
        end
        return ok;
    endfunction

endpackage

// File: rtl/sram_1w1r.sv
// rtl/sram_1w1r.sv - DEPTH x DATA_W array, byte-enabled write port, registered read port
//
// Ports: clk_i; i_we/i_waddr/i_wdata/i_wstrb write port (bytes with strobe set
// are written at the clock edge); i_re/i_raddr read request, o_rdata holds the
// word read at the last edge where i_re was high. A read and write to the same
// word in one cycle returns the old contents.
module sram_1w1r #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [DATA_W/8-1:0]      i_wstrb,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // No reset: array contents survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_burst_sram_slave.sv
// rtl/axi_burst_sram_slave.sv - AXI4 burst responder backed by an on-chip SRAM
//
// Ports: clk_i, rst_i (async, active high); AW channel awid/awaddr/awlen/
// awsize/awburst/awvalid/awready; W channel wdata/wstrb/wlast/wvalid/wready;
// B channel bid/bresp/bvalid/bready; AR channel arid/araddr/arlen/arsize/
// arburst/arvalid/arready; R channel rid/rdata/rresp/rlast/rvalid/rready.
// One write and one read burst may be in flight at the same time.
// Configuration: AXI_SLV_WRAP_EN enables WRAP bursts (see axi_pkg).
module axi_burst_sram_slave
    import axi_pkg::*;
#(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = AXI_ADDR_W,
    parameter int                DATA_W    = 32,
    parameter int                LEN_W     = AXI_LEN_W,
    parameter int                SIZE_W    = AXI_SIZE_W,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [SIZE_W-1:0] awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [2:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [SIZE_W-1:0] arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int unsigned LG    = $clog2(DATA_W / 8);
    localparam int          IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    // ---------------- write side ----------------
    wstate_t           r_wstate, w_wstate_nxt;
    logic [ID_W-1:0]   r_wid;
    logic [ADDR_W-1:0] r_waddr;
    logic [LEN_W-1:0]  r_wlen, r_wcnt;
    logic [SIZE_W-1:0] r_wsize;
    logic [1:0]        r_wburst;
    logic              r_werr;
    logic              w_aw_hs, w_w_beat, w_wlegal, w_wlast_bad;
    logic [ADDR_W-1:0] w_woff;
    logic [IDX_W-1:0]  w_widx;

    assign w_wlegal    = beat_legal(r_waddr, r_wsize, r_wlen, r_wburst, BASE_ADDR, DEPTH, LG);
    assign w_wlast_bad = (wlast != (r_wcnt == r_wlen));
    assign w_woff      = r_waddr - BASE_ADDR;
    assign w_widx      = IDX_W'(w_woff >> LG);

    always_comb begin
        w_wstate_nxt = r_wstate;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        w_aw_hs      = 1'b0;
        w_w_beat     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = ~rst_i;
                if (awvalid) begin
                    w_aw_hs      = 1'b1;
                    w_wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    w_w_beat = 1'b1;
                    if (r_wcnt == r_wlen) w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid    <= awid;
            r_waddr  <= awaddr;
            r_wlen   <= awlen;
            r_wsize  <= awsize;
            r_wburst <= awburst;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else if (w_w_beat) begin
            r_waddr <= axi_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
            r_wcnt  <= r_wcnt + LEN_W'(1);
            // wlast mismatches flag the burst but never cut it short
            if (!w_wlegal || w_wlast_bad) r_werr <= 1'b1;
        end
    end

    assign bid   = r_wid;
    assign bresp = (r_wstate == W_RESP && r_werr) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read side ----------------
    rstate_t           r_rstate, w_rstate_nxt;
    logic [ID_W-1:0]   r_rid;
    logic [ADDR_W-1:0] r_raddr;
    logic [LEN_W-1:0]  r_rlen, r_rcnt;
    logic [SIZE_W-1:0] r_rsize;
    logic [1:0]        r_rburst;
    logic              r_rlegal;
    logic              w_ar_hs, w_r_hs, w_sram_re, w_rlegal;
    logic [ADDR_W-1:0] w_roff;
    logic [IDX_W-1:0]  w_ridx;
    logic [DATA_W-1:0] w_sram_rdata;

    assign w_rlegal = beat_legal(r_raddr, r_rsize, r_rlen, r_rburst, BASE_ADDR, DEPTH, LG);
    assign w_roff   = r_raddr - BASE_ADDR;
    assign w_ridx   = IDX_W'(w_roff >> LG);

    always_comb begin
        w_rstate_nxt = r_rstate;
        arready      = 1'b0;
        w_ar_hs      = 1'b0;
        w_r_hs       = 1'b0;
        w_sram_re    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                arready = ~rst_i;
                if (arvalid) begin
                    w_ar_hs      = 1'b1;
                    w_rstate_nxt = R_FETCH;
                end
            end
            R_FETCH: begin
                w_sram_re    = 1'b1;
                w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (rready) begin
                    w_r_hs       = 1'b1;
                    w_rstate_nxt = (r_rcnt == r_rlen) ? R_IDLE : R_FETCH;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_rlegal <= 1'b0;
        end else if (w_ar_hs) begin
            r_rid    <= arid;
            r_raddr  <= araddr;
            r_rlen   <= arlen;
            r_rsize  <= arsize;
            r_rburst <= arburst;
            r_rcnt   <= '0;
        end else if (w_sram_re) begin
            // legality is captured alongside the fetch so R_DATA outputs stay stable
            r_rlegal <= w_rlegal;
        end else if (w_r_hs) begin
            r_raddr <= axi_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
            r_rcnt  <= r_rcnt + LEN_W'(1);
        end
    end

    assign rvalid = (r_rstate == R_DATA);
    assign rid    = r_rid;
    assign rlast  = rvalid && (r_rcnt == r_rlen);
    assign rresp  = (rvalid && !r_rlegal) ? RESP_SLVERR : RESP_OKAY;
    assign rdata  = (rvalid && r_rlegal) ? w_sram_rdata : '0;

    sram_1w1r #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk_i   (clk_i),
        .i_we    (w_w_beat && w_wlegal),
        .i_waddr (w_widx),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_re    (w_sram_re),
        .i_raddr (w_ridx),
        .o_rdata (w_sram_rdata)
    );

endmodule

// File: tb/tb_axi_burst_sram_slave.sv
// tb/tb_axi_burst_sram_slave.sv - directed self-checking bench for axi_burst_sram_slave
module tb_axi_burst_sram_slave;
    import axi_pkg::*;

    localparam int ID_W = 4;
    localparam int DW   = 32;
    localparam int TMO  = 50;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [ID_W-1:0] awid = '0, arid = '0;
    logic [31:0]   awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [2:0]    awsize = '0, arsize = '0;
    logic [1:0]    awburst = '0, arburst = '0;
    logic          awvalid = 1'b0, arvalid = 1'b0;
    logic          awready, arready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0, wvalid = 1'b0, wready;
    logic [ID_W-1:0] bid, rid;
    logic [2:0]    bresp, rresp;
    logic          bvalid, bready = 1'b0;
    logic [DW-1:0] rdata;
    logic          rlast, rvalid, rready = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0]     wr_data [16];
    logic [31:0]     rd_data [16];
    logic [2:0]      rd_resp [16];
    logic            rd_last [16];
    logic [ID_W-1:0] rd_id   [16];
    logic [2:0]      b_resp;
    logic [ID_W-1:0] b_id;

    always #5 clk_i = ~clk_i;

    axi_burst_sram_slave dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk_i);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < TMO) begin @(negedge clk_i); n++; end
        if (n >= TMO) begin total_cnt++; $display("FAIL aw_timeout: awready low for %0d cycles, required high", n); end
        @(negedge clk_i);
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk_i);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < TMO) begin @(negedge clk_i); n++; end
        if (n >= TMO) begin total_cnt++; $display("FAIL ar_timeout: arready low for %0d cycles, required high", n); end
        @(negedge clk_i);
        arvalid = 1'b0;
    endtask

    task automatic w_send(input int len, input logic [3:0] strb, input int last_at);
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            wdata = wr_data[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
            while (!wready && n < TMO) begin @(negedge clk_i); n++; end
            if (n >= TMO) begin total_cnt++; $display("FAIL w_timeout: beat %0d not accepted, required wready", i); end
            @(negedge clk_i);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv();
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < TMO) begin @(negedge clk_i); n++; end
        if (n >= TMO) begin total_cnt++; $display("FAIL b_timeout: bvalid low, required high"); end
        b_resp = bresp; b_id = bid;
        @(negedge clk_i);
        bready = 1'b0;
    endtask

    task automatic r_collect(input int len);
        rready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            while (!rvalid && n < TMO) begin @(negedge clk_i); n++; end
            if (n >= TMO) begin total_cnt++; $display("FAIL r_timeout: beat %0d rvalid low, required high", i); end
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id[i] = rid;
            @(negedge clk_i);
        end
        rready = 1'b0;
    endtask

    task automatic write_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [3:0] strb, input int last_at);
        aw_send(id, addr, 8'(len), size, burst);
        w_send(len, strb, last_at);
        b_recv();
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst);
        ar_send(id, addr, 8'(len), size, burst);
        r_collect(len);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total_cnt++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b00000)
            $display("FAIL reset_handshakes: got %b required 00000", {awready, wready, bvalid, arready, rvalid});
        else pass_cnt++;
        rst_i = 1'b0;
        @(negedge clk_i);
        total_cnt++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b10010)
            $display("FAIL idle_handshakes: got %b required 10010", {awready, wready, bvalid, arready, rvalid});
        else pass_cnt++;
        total_cnt++;
        if ({bid, bresp, rid, rdata, rresp, rlast} !== '0)
            $display("FAIL reset_payload: got %h required 0", {bid, bresp, rid, rdata, rresp, rlast});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        wr_data[0] = 32'h0BAD_0BAD;
        aw_send(4'd1, 32'h200, 8'd3, 3'd2, INCR);
        w_send(0, 4'hF, 3);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        total_cnt++;
        if ({awready, wready, bvalid} !== 3'b100)
            $display("FAIL mid_reset: got aw/w/b %b required 100", {awready, wready, bvalid});
        else pass_cnt++;
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
        write_burst(4'd3, 32'h10, 3, 3'd2, INCR, 4'hF, 3);
        total_cnt++;
        if ({b_id, b_resp} !== {4'd3, RESP_OKAY})
            $display("FAIL incr_b: got id %0d resp %0d required id 3 resp 0", b_id, b_resp);
        else pass_cnt++;
        ar_send(4'd5, 32'h10, 8'd3, 3'd2, INCR);
        total_cnt++;
        if (rvalid !== 1'b0) $display("FAIL incr_latency1: rvalid %b required 0", rvalid);
        else pass_cnt++;
        @(negedge clk_i);
        total_cnt++;
        if (rvalid !== 1'b1) $display("FAIL incr_latency2: rvalid %b required 1", rvalid);
        else pass_cnt++;
        r_collect(3);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({rd_id[i], rd_data[i], rd_resp[i], rd_last[i]} !== {4'd5, 32'hA0 + 32'(i), RESP_OKAY, i == 3})
                $display("FAIL incr_r%0d: got id %0d data %h resp %0d last %b required id 5 data %h resp 0 last %b",
                         i, rd_id[i], rd_data[i], rd_resp[i], rd_last[i], 32'hA0 + 32'(i), i == 3);
            else pass_cnt++;
        end
    endtask

    task automatic test_strobe();
        wr_data[0] = 32'hFFFF_FFFF;
        write_burst(4'd0, 32'h40, 0, 3'd2, INCR, 4'hF, 0);
        wr_data[0] = 32'h1122_3344;
        write_burst(4'd0, 32'h40, 0, 3'd2, INCR, 4'b0101, 0);
        read_burst(4'd0, 32'h40, 0, 3'd2, INCR);
        total_cnt++;
        if (rd_data[0] !== 32'hFF22_FF44) $display("FAIL strobe: got %h required ff22ff44", rd_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_mem [4];
        logic [2:0]  exp_resp;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hC0 + 32'(i);
        write_burst(4'd1, 32'h30, 3, 3'd2, INCR, 4'hF, 3);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hD0 + 32'(i);
        write_burst(4'd2, 32'h38, 3, 3'd2, WRAP, 4'hF, 3);
`ifdef AXI_SLV_WRAP_EN
        exp_resp = RESP_OKAY;
        exp_mem[0] = 32'hD2; exp_mem[1] = 32'hD3; exp_mem[2] = 32'hD0; exp_mem[3] = 32'hD1;
`else
        exp_resp = RESP_SLVERR;
        exp_mem[0] = 32'hC0; exp_mem[1] = 32'hC1; exp_mem[2] = 32'hC2; exp_mem[3] = 32'hC3;
`endif
        total_cnt++;
        if (b_resp !== exp_resp) $display("FAIL wrap_bresp: got %0d required %0d", b_resp, exp_resp);
        else pass_cnt++;
        read_burst(4'd1, 32'h30, 3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rd_data[i] !== exp_mem[i]) $display("FAIL wrap_mem%0d: got %h required %h", i, rd_data[i], exp_mem[i]);
            else pass_cnt++;
        end
        read_burst(4'd2, 32'h38, 3, 3'd2, WRAP);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ed;
`ifdef AXI_SLV_WRAP_EN
            ed = 32'hD0 + 32'(i);
`else
            ed = 32'h0;
`endif
            total_cnt++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {ed, exp_resp, i == 3})
                $display("FAIL wrap_rd%0d: got data %h resp %0d last %b required %h %0d %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], ed, exp_resp, i == 3);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundary();
        wr_data[0] = 32'h5A5A_1234;
        write_burst(4'd0, 32'hFFC, 0, 3'd2, INCR, 4'hF, 0);
        total_cnt++;
        if (b_resp !== RESP_OKAY) $display("FAIL top_word_bresp: got %0d required 0", b_resp);
        else pass_cnt++;
        read_burst(4'd6, 32'hFFC, 1, 3'd2, INCR);
        total_cnt++;
        if ({rd_data[0], rd_resp[0], rd_last[0]} !== {32'h5A5A_1234, RESP_OKAY, 1'b0})
            $display("FAIL bound_r0: got %h %0d %b required 5a5a1234 0 0", rd_data[0], rd_resp[0], rd_last[0]);
        else pass_cnt++;
        total_cnt++;
        if ({rd_data[1], rd_resp[1], rd_last[1]} !== {32'h0, RESP_SLVERR, 1'b1})
            $display("FAIL bound_r1: got %h %0d %b required 0 2 1", rd_data[1], rd_resp[1], rd_last[1]);
        else pass_cnt++;
        wr_data[0] = 32'h1;
        write_burst(4'd0, 32'h1000, 0, 3'd2, INCR, 4'hF, 0);
        total_cnt++;
        if (b_resp !== RESP_SLVERR) $display("FAIL oob_write: got %0d required 2", b_resp);
        else pass_cnt++;
    endtask

    task automatic test_early_wlast();
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hE0 + 32'(i);
        write_burst(4'd3, 32'h80, 3, 3'd2, INCR, 4'hF, 2);
        total_cnt++;
        if (b_resp !== RESP_SLVERR) $display("FAIL early_wlast: got %0d required 2", b_resp);
        else pass_cnt++;
        total_cnt++;
        if (awready !== 1'b1) $display("FAIL early_wlast_idle: awready %b required 1", awready);
        else pass_cnt++;
    endtask

    task automatic test_illegal_and_fixed();
        wr_data[0] = 32'h1234_5678;
        write_burst(4'd0, 32'h90, 0, 3'd2, INCR, 4'hF, 0);
        wr_data[0] = 32'hFFFF_FFFF;
        write_burst(4'd0, 32'h90, 0, 3'd3, INCR, 4'hF, 0);
        total_cnt++;
        if (b_resp !== RESP_SLVERR) $display("FAIL big_size_bresp: got %0d required 2", b_resp);
        else pass_cnt++;
        read_burst(4'd0, 32'h90, 0, 3'd2, INCR);
        total_cnt++;
        if (rd_data[0] !== 32'h1234_5678) $display("FAIL big_size_kept: got %h required 12345678", rd_data[0]);
        else pass_cnt++;
        read_burst(4'd0, 32'h90, 1, 3'd2, 2'b11);
        total_cnt++;
        if ({rd_data[0], rd_resp[0], rd_data[1], rd_resp[1], rd_last[1]} !== {32'h0, RESP_SLVERR, 32'h0, RESP_SLVERR, 1'b1})
            $display("FAIL burst3_read: got %h %0d %h %0d %b required 0 2 0 2 1",
                     rd_data[0], rd_resp[0], rd_data[1], rd_resp[1], rd_last[1]);
        else pass_cnt++;
        wr_data[0] = 32'h1; wr_data[1] = 32'h2; wr_data[2] = 32'h3;
        write_burst(4'd0, 32'h94, 2, 3'd2, FIXED, 4'hF, 2);
        read_burst(4'd0, 32'h94, 0, 3'd2, INCR);
        total_cnt++;
        if ({b_resp, rd_data[0]} !== {RESP_OKAY, 32'h3})
            $display("FAIL fixed: got resp %0d data %h required 0 00000003", b_resp, rd_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        wr_data[0] = 32'hBEEF_0001;
        aw_send(4'd7, 32'h100, 8'd0, 3'd2, INCR);
        w_send(0, 4'hF, 0);
        ar_send(4'd9, 32'h10, 8'd0, 3'd2, INCR);
        total_cnt++;
        if (bvalid !== 1'b1) $display("FAIL concurrent_ar: bvalid %b required 1 while AR accepted", bvalid);
        else pass_cnt++;
        @(negedge clk_i);
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if ({bvalid, bid, bresp} !== {1'b1, 4'd7, RESP_OKAY})
                $display("FAIL b_hold%0d: got %b %0d %0d required 1 7 0", c, bvalid, bid, bresp);
            else pass_cnt++;
            total_cnt++;
            if ({rvalid, rid, rdata, rresp, rlast} !== {1'b1, 4'd9, 32'hA0, RESP_OKAY, 1'b1})
                $display("FAIL r_hold%0d: got %b %0d %h %0d %b required 1 9 000000a0 0 1",
                         c, rvalid, rid, rdata, rresp, rlast);
            else pass_cnt++;
            @(negedge clk_i);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk_i);
        bready = 1'b0; rready = 1'b0;
        total_cnt++;
        if ({bvalid, rvalid, awready, arready} !== 4'b0011)
            $display("FAIL release: got b/r/aw/ar %b required 0011", {bvalid, rvalid, awready, arready});
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_incr();
        test_strobe();
        test_wrap();
        test_boundary();
        test_early_wlast();
        test_illegal_and_fixed();
        test_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_burst_sram_slave.md
Name: axi_burst_sram_slave

Overview:
- AXI4 responder (slave end of the bus) backed by an on-chip SRAM array; it is the counterpart to the CPU and DMA initiators.
- Serves write bursts (AW/W/B) and read bursts (AR/R) independently and concurrently.
- Supports FIXED, INCR and WRAP bursts, byte strobes, narrow sizes and per-beat error responses.
- Sits on a slave port of axi_bus as the scratchpad / DMA buffer target.

Parameters:
- ID_W, `ID_BITS, transaction ID width
- ADDR_W, `ADDR_WIDTH, address width
- DATA_W, `DATA_WIDTH, data width (32 or 64)
- LEN_W, `LEN_BITS, burst length field width
- SIZE_W, `SIZE_BITS, size field width
- DEPTH, 1024, SRAM words of DATA_W bits
- BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/LEN_W/SIZE_W/2  write address
- awvalid in 1; awready out 1
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data
- wready  out  1
- bid/bresp/bvalid  out  ID_W/3/1  write response; bready in 1
- arid/araddr/arlen/arsize/arburst/arvalid  in  as AW; arready out 1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/3/1/1  read data; rready in 1

Behaviour:
- Reset: all FSMs go IDLE. All valid and ready outputs are 0 while rst_i is high. bid, bresp, rid, rdata, rresp and rlast reset to 0.
- Reset mid-burst abandons the burst; no response is issued. SRAM contents are not cleared.
- resp encoding: 3'b000 OKAY, 3'b010 SLVERR.
- Write FSM, state W_IDLE: awready=1.
  - On AW handshake, latch id, addr, len, size and burst; clear beat counter and err flag; go to W_DATA.
- Write FSM, state W_DATA: wready=1. Each wvalid beat:
  - Writes the bytes whose wstrb bit is set to word (addr-BASE_ADDR)>>log2(DATA_W/8), when the beat is legal.
  - Then advances the address and increments the counter.
  - At counter==len, go to W_RESP.
  - err is set by any of: illegal beat; wlast=1 before beat len; wlast=0 on beat len.
- Write FSM, state W_RESP: bvalid=1, bid=latched id, bresp=err?SLVERR:OKAY. These are held stable until bready, then return to W_IDLE.
- AW is not accepted again until the B handshake completes (single outstanding write).
- Read FSM, state R_IDLE: arready=1. On AR handshake, latch fields and go to R_FETCH.
- Read FSM, state R_FETCH: registered SRAM read of the current address; go to R_DATA next cycle.
- Read FSM, state R_DATA:
  - Outputs: rvalid=1, rid, rdata, rresp and rlast=(counter==len), all held stable until rready.
  - On handshake: advance the address and counter. Go to R_IDLE if last, else R_FETCH.
  - Throughput is one beat per 2 cycles; first-beat latency is 2 cycles after the AR handshake.
- Illegal beat: any of the following:
  - size > log2(DATA_W/8);
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8);
  - burst==2'b11;
  - WRAP with len not in {1,3,7,15};
  - WRAP while the feature is disabled.
- On an illegal beat the write is suppressed, or the read returns rdata=0 with rresp=SLVERR for that beat. The burst still runs to its full length.
- Address update per burst type:
  - FIXED: address unchanged.
  - INCR: addr += 1<<size.
  - WRAP: addr = (addr & ~M) | ((addr+(1<<size)) & M), where M = ((len+1)<<size)-1.
- Narrow transfers use wstrb as given. Read data is the full word.
- Same-cycle read and write to one word: the read returns the old data and the write takes effect after the edge.
- Unaligned start address: the address is used as given for the first beat, and subsequent INCR beats are aligned to size.

Optional Feature:
- Macro AXI_SLV_WRAP_EN.
- Defined: WRAP bursts are performed as described above.
- Undefined: WRAP bursts are illegal. Every beat gets SLVERR, nothing is written, and read data is 0. The handshake and beat count are unchanged.

Decomposition:
- Shared package axi_pkg holds:
  - burst_t enum (FIXED=0, INCR=1, WRAP=2);
  - resp constants RESP_OKAY and RESP_SLVERR (3-bit);
  - function axi_next_addr(addr, size, len, burst);
  - function beat_legal(addr, size, len, burst, base, depth).
- One sub-module, sram_1w1r: DEPTH x DATA_W array with a byte-enabled write port and a registered read port.

Test Plan:
- INCR write at 0x10, len=3, size=2, data 0xA0..0xA3, strb=0xF, then INCR read of the same -> bresp=0; reads return 0xA0..0xA3 with rlast only on the 4th beat and rresp=0.
- Write 0x1122_3344 with strb=4'b0101 over word 0xFFFF_FFFF at 0x40, then read 0x40 -> 0xFF22_FF44.
- WRAP write at 0x38, len=3, size=2 (with AXI_SLV_WRAP_EN) -> beats land at 0x38, 0x3C, 0x30, 0x34. Without the macro: bresp=3'b010 and memory unchanged.
- Read at BASE+DEPTH*4-4, INCR len=1 -> beat0 rresp=0 with valid data; beat1 rresp=3'b010 with rdata=0.
- Write len=3 with wlast asserted on beat 2 -> 4 beats are accepted and bresp=3'b010.
- Backpressure: bready and rready held low for 5 cycles -> bvalid, rvalid and all payloads stay stable. A concurrent AR is accepted while the write sits in W_RESP.
